// File: rtl/multi_debounce_pkg.sv
// Shared constants and types for the multi-channel button debouncer.
// Default periods assume a 50 MHz clock.
package multi_debounce_pkg;

  localparam int DEFAULT_DEBOUNCE_PERIOD = 1_000_000;  // 20 ms
  localparam int DEFAULT_LONG_PERIOD     = 50_000_000; // 1 s
  localparam int DEFAULT_REPEAT_PERIOD   = 10_000_000; // 200 ms

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    LONG   = 2'd2,
    REPEAT = 2'd3
  } hold_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, symmetric debounce counter and
// hold FSM producing press/release/long/repeat pulses. All outputs are registered.
module debounce_channel
  import multi_debounce_pkg::*;
#(
  parameter int DEBOUNCE_PERIOD = DEFAULT_DEBOUNCE_PERIOD,
  parameter int LONG_PERIOD     = DEFAULT_LONG_PERIOD,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DB_W     = $clog2(DEBOUNCE_PERIOD) + 1;
  localparam int HOLD_MAX = (LONG_PERIOD > REPEAT_PERIOD) ? LONG_PERIOD : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_PERIOD - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PERIOD - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  logic              sync_q1;
  logic              sync_q2;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  hold_state_e       state;
  logic              accept;

  // A level change is accepted on the DEBOUNCE_PERIOD-th consecutive disagreeing cycle.
  assign accept = (sync_q2 != btn_state) && (db_cnt == DB_LAST);

  // NOTE: every register here, synchronizer included, is cleared by the async reset
  // so a button held through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1       <= 1'b0;
      sync_q2       <= 1'b0;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      state         <= IDLE;
      btn_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every decision below uses the
      // pre-edge values of btn_state, counters and state.
      sync_q1       <= btn_in;
      sync_q2       <= sync_q1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      if (sync_q2 == btn_state) begin
        db_cnt <= '0;
      end else if (accept) begin
        db_cnt        <= '0;
        btn_state     <= sync_q2;
        press_pulse   <= sync_q2;
        release_pulse <= ~sync_q2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      // An accepted release overrides any long/repeat event due on the same edge.
      if (accept && !sync_q2) begin
        state    <= IDLE;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept && sync_q2) begin
              state    <= HELD;
              hold_cnt <= '0;
            end
          end
          HELD: begin
            if (hold_cnt == LONG_LAST) begin
              long_pulse <= 1'b1;
              hold_cnt   <= '0;
              state      <= (REPEAT_PERIOD > 0) ? REPEAT : LONG;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          LONG: begin
            hold_cnt <= hold_cnt;  // parked until release; counter never wraps
          end
          REPEAT: begin
            if (hold_cnt == REP_LAST) begin
              repeat_pulse <= 1'b1;
              hold_cnt     <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_debounce.sv
// Array of independent debounce channels with long-press and auto-repeat events.
// The top level only validates parameters and replicates debounce_channel.
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_PERIOD = DEFAULT_DEBOUNCE_PERIOD,
  parameter int LONG_PERIOD     = DEFAULT_LONG_PERIOD,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_state,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse
);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("multi_debounce: N_CH must be in 1..32");
  end
  if (DEBOUNCE_PERIOD < 1) begin : g_bad_debounce
    $error("multi_debounce: DEBOUNCE_PERIOD must be at least 1");
  end
  if (LONG_PERIOD < 1) begin : g_bad_long
    $error("multi_debounce: LONG_PERIOD must be greater than 0");
  end
  if (REPEAT_PERIOD < 0) begin : g_bad_repeat
    $error("multi_debounce: REPEAT_PERIOD must not be negative");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_PERIOD(DEBOUNCE_PERIOD),
      .LONG_PERIOD    (LONG_PERIOD),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_channel (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_in       (btn_in[i]),
      .btn_state    (btn_state[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

endmodule
